sound_player: RTL and testbench
===============================

// Module: sound_player
// PURPOSE
//  Parametrised successor of the single-bit sound output: plays one tone per
//  request, selected by code_sound from a fixed table (pitch + duration).
//  Generates a square wave on 'sound', then inserts a silent gap, then
//  reports completion. Sits between game/screen logic and the speaker pin.
// PARAMETERS
//  CODE_W   3      width of code_sound; code 0 = no sound
//  HALF_W   16     width of half-period counter (clk cycles)
//  DUR_W    10     width of duration counter (ms ticks)
//  TICK_DIV 12000  clk cycles per ms tick (12 MHz board)
//  GAP_MS   20     silent ticks after each tone
// PORTS
//  clk         in   1       system clock, all logic rising-edge
//  rstn        in   1       synchronous reset, active low
//  mute        in   1       force sound low; sequencing continues
//  play        in   1       request strobe, sampled each edge
//  code_sound  in   CODE_W  tone code, sampled with play
//  busy        out  1       tone or gap in progress
//  done        out  1       one-cycle pulse at end of gap
//  sound       out  1       registered square-wave output
// BEHAVIOUR
//  - Reset (rstn=0 at edge): state IDLE; sound=0, busy=0, done=0, all counters 0;
//    applies mid-tone/mid-gap, no done pulse.
//  - FSM IDLE -> TONE -> GAP -> IDLE.
//  - IDLE: play=1 && code_sound!=0 at edge k -> latch code, load half=tone_half(code),
//    dur=tone_ms(code), clear prescaler/phase; TONE from cycle k+1, busy=1.
//    play with code 0 ignored (no busy, no done).
//  - play while busy is ignored; code is not re-latched.
//  - TONE: phase starts 1; half-period counter counts 0..half-1, phase toggles on
//    wrap. Prescaler counts 0..TICK_DIV-1; dur decrements per tick; on dur reaching
//    0 -> GAP. Duration exactly tone_ms*TICK_DIV cycles.
//  - GAP: phase=0 for GAP_MS*TICK_DIV cycles, then IDLE; in first IDLE cycle
//    busy=0, done=1 (single cycle).
//  - sound register <= phase & ~mute (& volume gate when enabled); mute affects
//    output from the next edge only, never timing.
//  - Table entries with half=0 or ms=0 treated as code 0 (rejected).
// CONFIGURATION
//  SOUND_VOLUME_EN defined: extra input 'volume' [3:0]; 4-bit free-running PWM
//    counter; during phase=1, sound=(pwm_cnt < volume); volume=0 silent,
//    15 = 15/16 duty.
//  Not defined: no volume port; sound = phase & ~mute.
// STRUCTURE
//  sound_pkg: state enum localparams (S_IDLE/S_TONE/S_GAP), tone table functions
//    tone_half(code), tone_ms(code), default widths.
//  Sub-module sound_tick: ms prescaler with clear and tick output.
// TESTING (TICK_DIV=10, GAP_MS=2, table code1: half=4, ms=3)
//  1 play code1 at edge k -> busy at k+1; sound 1111 0000 repeating; sound 0 from
//    k+31; done=1, busy=0 at k+51 only.
//  2 play code0 in IDLE -> busy, done, sound stay 0 for 100 cycles.
//  3 second play code1 at k+10 during tone -> ignored; timing identical to test 1.
//  4 mute=1 during k+5..k+20 -> sound 0 from next edge; done still at k+51.
//  5 rstn=0 at k+15 -> next cycle busy=0, sound=0, no done; new play works.
//  6 SOUND_VOLUME_EN, volume=4, long half-period -> high phase duty 4/16; volume=0 -> sound 0.

Source files
------------

// File: rtl/sound_player_pkg.sv
// Shared definitions for the sound player: FSM state type, default widths
// and the fixed tone table (half-period in clk cycles, duration in ms ticks).
// A table entry with a zero half-period or zero duration marks an unusable
// code; the player rejects it exactly like code 0.
package sound_pkg;

    localparam int CODE_W_DEF   = 3;
    localparam int HALF_W_DEF   = 16;
    localparam int DUR_W_DEF    = 10;
    localparam int TICK_DIV_DEF = 12000;
    localparam int GAP_MS_DEF   = 20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TONE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Half-period of the square wave for each code, in clk cycles
    function automatic logic [HALF_W_DEF-1:0] tone_half(input int unsigned code);
        case (code)
            1:       tone_half = 16'd4;
            2:       tone_half = 16'd6000;
            3:       tone_half = 16'd4545;
            4:       tone_half = 16'd12000;
            5:       tone_half = 16'd0;
            6:       tone_half = 16'd3000;
            7:       tone_half = 16'd20;
            default: tone_half = 16'd0;
        endcase
    endfunction

    // Tone length for each code, in ms ticks
    function automatic logic [DUR_W_DEF-1:0] tone_ms(input int unsigned code);
        case (code)
            1:       tone_ms = 10'd3;
            2:       tone_ms = 10'd100;
            3:       tone_ms = 10'd150;
            4:       tone_ms = 10'd50;
            5:       tone_ms = 10'd80;
            6:       tone_ms = 10'd0;
            7:       tone_ms = 10'd5;
            default: tone_ms = 10'd0;
        endcase
    endfunction

endpackage

// File: rtl/sound_player_tick.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and pulses 'tick' on the last
// count. 'clear' restarts the count so a new tone starts on a tick boundary.
module sound_tick #(
    parameter int TICK_DIV = 12000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(TICK_DIV - 1));

    // Prescaler count, wrapping after the tick cycle or restarting on clear
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sound_player.sv
// Tone player: on a play strobe with a valid code it emits a square wave for
// the table duration, then a silent gap, then a one-cycle done pulse.
// The sound register loads the next phase value directly, so 'sound' lines up
// with the state: high in the first tone cycle, low from the first gap cycle.
// Optional feature macro SOUND_VOLUME_EN: adds a 4-bit 'volume' input that
// PWM-gates the high phase with a free-running 4-bit counter.
module sound_player
    import sound_pkg::*;
#(
    parameter int CODE_W   = CODE_W_DEF,
    parameter int HALF_W   = HALF_W_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int GAP_MS   = GAP_MS_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              mute,
    input  logic              play,
    input  logic [CODE_W-1:0] code_sound,
`ifdef SOUND_VOLUME_EN
    input  logic [3:0]        volume,
`endif
    output logic              busy,
    output logic              done,
    output logic              sound
);

    state_t            state, state_n;
    logic [HALF_W-1:0] half_len, half_len_n;
    logic [HALF_W-1:0] half_cnt, half_cnt_n;
    logic [DUR_W-1:0]  dur_cnt, dur_n;
    logic              phase, phase_n;
    logic              done_n;
    logic              sound_n;
    logic              tick;
    logic              tick_clear;
    logic              gate;
    logic [HALF_W-1:0] req_half;
    logic [DUR_W-1:0]  req_ms;
    logic              req_ok;

    assign req_half = HALF_W'(tone_half(32'(code_sound)));
    assign req_ms   = DUR_W'(tone_ms(32'(code_sound)));
    assign req_ok   = (req_half != '0) && (req_ms != '0);
    assign busy     = (state != S_IDLE);

    sound_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rstn  (rstn),
        .clear (tick_clear),
        .tick  (tick)
    );

`ifdef SOUND_VOLUME_EN
    logic [3:0] pwm_cnt;

    // Free-running PWM counter used to scale the high phase by volume/16
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    assign gate = (pwm_cnt < volume);
`else
    assign gate = 1'b1;
`endif

    // Sequencing: accept a request, run the tone, then the gap, then report
    always_comb begin
        state_n    = state;
        half_len_n = half_len;
        half_cnt_n = half_cnt;
        dur_n      = dur_cnt;
        phase_n    = phase;
        done_n     = 1'b0;
        tick_clear = 1'b0;
        case (state)
            S_IDLE: begin
                if (play && req_ok) begin
                    state_n    = S_TONE;
                    half_len_n = req_half;
                    half_cnt_n = '0;
                    dur_n      = req_ms;
                    phase_n    = 1'b1;
                    tick_clear = 1'b1;
                end
            end
            S_TONE: begin
                if (half_cnt == half_len - HALF_W'(1)) begin
                    half_cnt_n = '0;
                    phase_n    = ~phase;
                end else begin
                    half_cnt_n = half_cnt + HALF_W'(1);
                end
                if (tick) begin
                    if (dur_cnt == DUR_W'(1)) begin
                        half_cnt_n = '0;
                        phase_n    = 1'b0;
                        if (GAP_MS == 0) begin
                            state_n = S_IDLE;
                            dur_n   = '0;
                            done_n  = 1'b1;
                        end else begin
                            state_n = S_GAP;
                            dur_n   = DUR_W'(GAP_MS);
                        end
                    end else begin
                        dur_n = dur_cnt - DUR_W'(1);
                    end
                end
            end
            S_GAP: begin
                phase_n = 1'b0;
                if (tick) begin
                    if (dur_cnt == DUR_W'(1)) begin
                        state_n = S_IDLE;
                        dur_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        dur_n = dur_cnt - DUR_W'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                phase_n = 1'b0;
                dur_n   = '0;
            end
        endcase
        sound_n = phase_n & ~mute & gate;
    end

    // State and datapath registers, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            half_len <= '0;
            half_cnt <= '0;
            dur_cnt  <= '0;
            phase    <= 1'b0;
            done     <= 1'b0;
            sound    <= 1'b0;
        end else begin
            state    <= state_n;
            half_len <= half_len_n;
            half_cnt <= half_cnt_n;
            dur_cnt  <= dur_n;
            phase    <= phase_n;
            done     <= done_n;
            sound    <= sound_n;
        end
    end

endmodule

// File: tb/tb_sound_player.sv
// Testbench for sound_player with TICK_DIV=10, GAP_MS=2.
// A cycle-level reference model (tone position computed from elapsed cycles)
// is checked every cycle, alongside fixed timing vectors and hand sequences.
module tb_sound_player;

    localparam int TICK = 10;
    localparam int GAP  = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       mute = 1'b0;
    logic       play = 1'b0;
    logic [2:0] code_sound = 3'd0;
`ifdef SOUND_VOLUME_EN
    logic [3:0] volume = 4'd15;
`endif
    logic       busy, done, sound;

    int checks = 0;
    int failures = 0;

    // Reference tone table, indexed by code
    int tb_half [8] = '{0, 4, 6000, 4545, 12000, 0, 3000, 20};
    int tb_ms   [8] = '{0, 3, 100, 150, 50, 80, 0, 5};

    // Reference model state: elapsed cycles since the tone started
    bit       m_active = 1'b0;
    int       m_rel = 0;
    int       m_half = 1;
    int       m_tone = 0;
    int       m_total = 0;
    int       m_pwm = 0;
    logic [2:0] m_exp = 3'b000;

    typedef struct {
        int         scen;
        int         cyc;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs [$];

    sound_player #(
        .TICK_DIV (TICK),
        .GAP_MS   (GAP)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .mute       (mute),
        .play       (play),
        .code_sound (code_sound),
`ifdef SOUND_VOLUME_EN
        .volume     (volume),
`endif
        .busy       (busy),
        .done       (done),
        .sound      (sound)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [2:0] got, input logic [2:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s busy/done/sound got=%b want=%b at %0t", name, got, want, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_edge(input logic r, input logic p, input logic [2:0] c, input logic m);
        bit gate;
        bit ph;
        gate = 1'b1;
`ifdef SOUND_VOLUME_EN
        gate = (m_pwm < int'(volume));
        m_pwm = r ? (m_pwm + 1) % 16 : 0;
`endif
        if (!r) begin
            m_active = 1'b0;
            m_exp = 3'b000;
        end else begin
            m_exp[1] = 1'b0;
            if (m_active) begin
                m_rel++;
                if (m_rel == m_total) begin
                    m_active = 1'b0;
                    m_exp[1] = 1'b1;
                end
            end else if (p && tb_half[c] != 0 && tb_ms[c] != 0) begin
                m_active = 1'b1;
                m_rel = 0;
                m_half = tb_half[c];
                m_tone = tb_ms[c] * TICK;
                m_total = m_tone + GAP * TICK;
            end
            ph = m_active && (m_rel < m_tone) && (((m_rel / m_half) % 2) == 0);
            m_exp[2] = m_active;
            m_exp[0] = ph && !m && gate;
        end
    endtask

    // Drive one cycle of inputs, clock it, and compare against the model
    task automatic apply_stimulus(input logic r, input logic p, input logic [2:0] c, input logic m);
        rstn = r;
        play = p;
        code_sound = c;
        mute = m;
        @(posedge clk);
        model_edge(r, p, c, m);
        #1;
        check_output("model", {busy, done, sound}, m_exp);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        int     len;
        logic [2:0] sc_code;
        bit     done_seen;
        int     highs;

        // Timing vectors for code 1 (half=4, ms=3); cycle 1 follows the play edge
        vecs.push_back('{1, 1,  3'b101});
        vecs.push_back('{1, 4,  3'b101});
        vecs.push_back('{1, 5,  3'b100});
        vecs.push_back('{1, 8,  3'b100});
        vecs.push_back('{1, 9,  3'b101});
        vecs.push_back('{1, 28, 3'b101});
        vecs.push_back('{1, 29, 3'b100});
        vecs.push_back('{1, 30, 3'b100});
        vecs.push_back('{1, 31, 3'b100});
        vecs.push_back('{1, 50, 3'b100});
        vecs.push_back('{1, 51, 3'b010});
        vecs.push_back('{1, 52, 3'b000});
        vecs.push_back('{2, 1,  3'b000});
        vecs.push_back('{2, 50, 3'b000});
        vecs.push_back('{2, 100, 3'b000});
        vecs.push_back('{3, 11, 3'b101});
        vecs.push_back('{3, 30, 3'b100});
        vecs.push_back('{3, 31, 3'b100});
        vecs.push_back('{3, 51, 3'b010});
        vecs.push_back('{3, 52, 3'b000});
        vecs.push_back('{4, 4,  3'b101});
        vecs.push_back('{4, 9,  3'b100});
        vecs.push_back('{4, 20, 3'b100});
        vecs.push_back('{4, 25, 3'b101});
        vecs.push_back('{4, 51, 3'b010});
        vecs.push_back('{5, 1,  3'b000});
        vecs.push_back('{5, 40, 3'b000});
        vecs.push_back('{6, 1,  3'b000});
        vecs.push_back('{6, 40, 3'b000});

        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 3'd0, 1'b0);
        check_output("reset", {busy, done, sound}, 3'b000);
        idle_cycles(3);

        // Scenarios: 1 plain, 2 code 0, 3 replay during tone, 4 mute window,
        // 5 code 5 (zero half-period), 6 code 6 (zero duration)
        for (int s = 1; s <= 6; s++) begin
            len = (s == 2) ? 101 : 56;
            sc_code = (s == 2) ? 3'd0 : (s == 5) ? 3'd5 : (s == 6) ? 3'd6 : 3'd1;
            for (int j = 0; j < len; j++) begin
                apply_stimulus(1'b1,
                               (j == 0) || (s == 3 && j == 10),
                               sc_code,
                               (s == 4) && (j >= 5) && (j <= 20));
                foreach (vecs[v]) begin
                    if (vecs[v].scen == s && vecs[v].cyc == j + 1)
                        check_output($sformatf("vec_s%0d_c%0d", s, j + 1), {busy, done, sound}, vecs[v].exp);
                end
            end
            idle_cycles(4);
        end

        // Reset in the middle of a tone: no done afterwards, then a fresh play
        apply_stimulus(1'b1, 1'b1, 3'd1, 1'b0);
        for (int j = 1; j < 15; j++) apply_stimulus(1'b1, 1'b0, 3'd0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 3'd0, 1'b0);
        check_output("mid_reset", {busy, done, sound}, 3'b000);
        done_seen = 1'b0;
        for (int j = 0; j < 60; j++) begin
            apply_stimulus(1'b1, 1'b0, 3'd0, 1'b0);
            done_seen |= done;
        end
        check_output("no_done_after_reset", {2'b00, done_seen}, 3'b000);
        apply_stimulus(1'b1, 1'b1, 3'd1, 1'b0);
        check_output("replay_start", {busy, done, sound}, 3'b101);
        for (int j = 1; j < 52; j++) begin
            apply_stimulus(1'b1, 1'b0, 3'd0, 1'b0);
            if (j == 50) check_output("replay_done", {busy, done, sound}, 3'b010);
        end

`ifdef SOUND_VOLUME_EN
        // Volume PWM: code 4 stays in the high phase for its whole 500 cycles
        volume = 4'd4;
        idle_cycles(3);
        highs = 0;
        apply_stimulus(1'b1, 1'b1, 3'd4, 1'b0);
        highs += int'(sound);
        for (int j = 1; j < 480; j++) begin
            apply_stimulus(1'b1, 1'b0, 3'd0, 1'b0);
            highs += int'(sound);
        end
        check_output("duty_vol4", 3'(highs == 120), 3'd1);
        idle_cycles(60);
        volume = 4'd0;
        highs = 0;
        apply_stimulus(1'b1, 1'b1, 3'd4, 1'b0);
        highs += int'(sound);
        for (int j = 1; j < 480; j++) begin
            apply_stimulus(1'b1, 1'b0, 3'd0, 1'b0);
            highs += int'(sound);
        end
        check_output("duty_vol0", 3'(highs == 0), 3'd1);
        idle_cycles(60);
`else
        highs = 0;
`endif

        // Randomized traffic checked cycle by cycle against the model
        begin
            logic rm;
            rm = 1'b0;
            for (int j = 0; j < 6000; j++) begin
                if ($urandom_range(0, 24) == 0) rm = ~rm;
`ifdef SOUND_VOLUME_EN
                if ($urandom_range(0, 99) == 0) volume = 4'($urandom_range(0, 15));
`endif
                apply_stimulus($urandom_range(0, 499) != 0,
                               $urandom_range(0, 29) == 0,
                               3'($urandom_range(0, 7)),
                               rm);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
